// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core: stall/flush sequencing,
// EX forwarding selects, data-memory wait FSM with timeout fault, and stall perf counter.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [1:0]       result_sel_e,
  input  logic             reg_write_m,
  input  logic [4:0]       rd_m,
  input  logic             reg_write_w,
  input  logic [4:0]       rd_w,
  input  logic             pc_src_e,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  input  logic             err_in,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             halted,
  output logic             fault_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  // state    | meaning
  // RUN      | normal issue
  // MEM_WAIT | data memory not ready, pipeline frozen
  // HALT     | sticky stop until reset
  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mw, lu, any_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic wm, input logic [4:0] rdm,
                                         input logic ww, input logic [4:0] rdw);
    if (wm && rdm != 5'd0 && rdm == rs)      return 2'b10;
    else if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
    else                                     return 2'b00;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    fault_d    = fault_q;
    case (state_q)
      S_RUN: begin
        if (err_in) begin
          state_d = S_HALT;
        end else if (mem_req_m && !mem_ready) begin
          state_d    = S_MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      S_MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    mw = ((state_q == S_RUN) && mem_req_m && !mem_ready) ||
         ((state_q == S_MEM_WAIT) && !mem_ready);
    lu = (result_sel_e == 2'b01) && (rd_e != 5'd0) &&
         ((rd_e == rs1_d) || (rd_e == rs2_d));
    if (rst) begin
      if (state_q == S_HALT || mw) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (pc_src_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lu) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign any_stall = stall_f | stall_d | stall_e | stall_m;

  always_comb begin
    cnt_d = cnt_q;
    if (any_stall && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
  end

  assign fwd_a_e       = rst ? fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w) : 2'b00;
  assign fwd_b_e       = rst ? fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w) : 2'b00;
  assign halted        = (state_q == S_HALT);
  assign fault_timeout = fault_q;
  assign stall_cycles  = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: behavioural model checked every cycle plus hand literals.
module tb_hazard_ctrl;
  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] result_sel_e;
  logic reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ready, err_in;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic halted, fault_timeout;
  logic [CW-1:0] stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .result_sel_e(result_sel_e), .reg_write_m(reg_write_m), .rd_m(rd_m),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .pc_src_e(pc_src_e),
    .mem_req_m(mem_req_m), .mem_ready(mem_ready), .err_in(err_in),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .halted(halted),
    .fault_timeout(fault_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a halted flag, a count of consecutive not-ready wait cycles, a sticky
  // fault flag and a saturating integer stall counter.
  bit m_halt, m_fault;
  int m_wait, m_cnt;

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  function automatic logic [6:0] exp_ctl();
    logic waiting, load_use;
    if (!rst) return 7'b0;
    if (m_halt) return 7'b1111_001;
    waiting  = !mem_ready && (m_wait > 0 || mem_req_m);
    load_use = result_sel_e == 2'd1 && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    if (waiting)  return 7'b1111_001;
    if (pc_src_e) return 7'b0000_110;
    if (load_use) return 7'b1100_010;
    return 7'b0;
  endfunction

  function automatic int exp_fwd(input logic [4:0] rs);
    if (!rst) return 0;
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_halt = 0; m_fault = 0; m_wait = 0; m_cnt = 0;
    end else begin
      if (exp_ctl()[6:3] != 0 && m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (!m_halt) begin
        if (m_wait == 0) begin
          if (err_in) m_halt = 1;
          else if (mem_req_m && !mem_ready) m_wait = 1;
        end else if (mem_ready) begin
          m_wait = 0;
        end else if (m_wait >= TO) begin
          m_halt = 1; m_fault = 1;
        end else begin
          m_wait = m_wait + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("ctl", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}, exp_ctl());
    chk("fwd_a", fwd_a_e, exp_fwd(rs1_e));
    chk("fwd_b", fwd_b_e, exp_fwd(rs2_e));
    chk("halted", halted, m_halt);
    chk("fault", fault_timeout, m_fault);
    chk("cnt", stall_cycles, m_cnt);
  end

  task automatic clr();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    result_sel_e = 0; reg_write_m = 0; reg_write_w = 0; pc_src_e = 0;
    mem_req_m = 0; mem_ready = 0; err_in = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; clr();
    nxt(); nxt();
    rst = 1'b1;
  endtask

  initial begin
    clr();
    @(negedge clk);
    chk("rst_ctl", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}, 0);
    chk("rst_cnt", stall_cycles, 0);
    nxt(); rst = 1'b1;

    // load-use: one bubble
    result_sel_e = 2'b01; rd_e = 5; rs1_d = 5;
    @(negedge clk);
    chk("lu_stall", {stall_f, stall_d, flush_e, stall_e}, 4'b1110);
    nxt(); clr();
    @(negedge clk);
    chk("lu_release", {stall_f, stall_d, flush_e}, 0);
    chk("lu_cnt", stall_cycles, 1);

    // forwarding priority
    nxt(); rd_m = 7; rd_w = 7; rs1_e = 7; rs2_e = 7; reg_write_m = 1; reg_write_w = 1;
    @(negedge clk); chk("fwd_mem", fwd_a_e, 2);
    nxt(); rd_m = 0;
    @(negedge clk); chk("fwd_wb", fwd_a_e, 1);
    nxt(); rd_w = 0;
    @(negedge clk); chk("fwd_none", fwd_a_e, 0);

    // branch beats load-use
    nxt(); clr(); pc_src_e = 1; result_sel_e = 2'b01; rd_e = 3; rs2_d = 3;
    @(negedge clk);
    chk("br_lu", {flush_d, flush_e, stall_f, stall_d}, 4'b1100);

    // 3-cycle memory wait
    nxt(); do_reset();
    mem_req_m = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mw_hold", {stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e}, 7'b1111100);
      nxt();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("mw_release", {stall_f, stall_m, flush_w}, 0);
    nxt(); clr();
    @(negedge clk);
    chk("mw_cnt", stall_cycles, 3);

    // err_in ignored while waiting, taken from RUN
    nxt(); do_reset();
    mem_req_m = 1; mem_ready = 0;
    nxt(); err_in = 1;
    nxt(); err_in = 0; mem_ready = 1;
    nxt(); clr();
    @(negedge clk); chk("err_wait_ign", halted, 0);
    nxt(); err_in = 1;
    nxt(); clr();
    @(negedge clk); chk("err_run_halt", halted, 1);
    chk("err_no_fault", fault_timeout, 0);

    // timeout: one RUN wait cycle then TO MEM_WAIT cycles, then HALT
    nxt(); do_reset();
    mem_req_m = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) nxt();
    @(negedge clk); chk("to_not_yet", halted, 0);
    nxt();
    @(negedge clk);
    chk("to_halt", halted, 1);
    chk("to_fault", fault_timeout, 1);
    chk("to_cnt5", stall_cycles, 5);
    mem_ready = 1;
    for (int i = 0; i < 12; i++) nxt();
    @(negedge clk);
    chk("to_sticky", halted, 1);
    chk("cnt_sat", stall_cycles, CMAX);

    // reset mid-wait
    nxt(); do_reset();
    mem_req_m = 1; mem_ready = 0;
    nxt(); nxt();
    @(negedge clk); #2;
    rst = 1'b0; #1;
    chk("rstw_ctl", {stall_f, stall_d, stall_e, stall_m, flush_w}, 0);
    chk("rstw_cnt", stall_cycles, 0);
    nxt(); clr(); rst = 1'b1;
    @(negedge clk);
    chk("rstw_run", {halted, stall_f}, 0);
    chk("rstw_cnt2", stall_cycles, 0);
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
